sar_key_search: RTL and testbench



---
 rtl/sar_key_search_if.sv | 40 ++++
 rtl/sar_key_search.sv | 138 +++++++++++++
 tb/tb_sar_key_search.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_key_search_if.sv
// ----------------------------------------------------------------------------
// sar_key_search_if
// Groups the signals between the successive-approximation search controller
// and the parties around it: the requester (START), the 4-bit magnitude
// comparator (GT/EQ/LT in, TRIAL out to its A input) and the result consumer.
//
//   START   requester -> controller   request a search (sampled in IDLE)
//   GT/EQ/LT comparator -> controller flags for TRIAL vs. key
//   TRIAL   controller -> comparator  registered trial operand
//   CMP_E   controller -> comparator  comparator enable (TEST/VERIFY only)
//   BUSY, DONE, FOUND, RESULT, ERR    status/result back to the requester
//
// master: the environment (requester + comparator)
// slave : the search controller
// ----------------------------------------------------------------------------
interface sar_key_search_if #(
    parameter int N = 4
);
    logic         START;
    logic         GT;
    logic         EQ;
    logic         LT;
    logic [N-1:0] TRIAL;
    logic         CMP_E;
    logic         BUSY;
    logic         DONE;
    logic         FOUND;
    logic [N-1:0] RESULT;
    logic         ERR;

    modport master (
        output START, GT, EQ, LT,
        input  TRIAL, CMP_E, BUSY, DONE, FOUND, RESULT, ERR
    );

    modport slave (
        input  START, GT, EQ, LT,
        output TRIAL, CMP_E, BUSY, DONE, FOUND, RESULT, ERR
    );
endinterface

// File: rtl/sar_key_search.sv
// ----------------------------------------------------------------------------
// sar_key_search
// Successive-approximation controller that drives the A input of a magnitude
// comparator and walks the trial operand towards the unknown key on B, one
// bit per cycle from the MSB down. An EQ flag during the bit tests ends the
// search early; otherwise a final VERIFY cycle re-checks the decided value.
// Any flag sample that is not exactly one-hot sets the sticky ERR flag.
//
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous, active-high reset (aborts a search, no DONE issued)
//   bus  slave side of sar_key_search_if:
//          START in, GT/EQ/LT in, TRIAL out, CMP_E out, BUSY out,
//          DONE out (1-cycle pulse), FOUND out, RESULT out, ERR out
// ----------------------------------------------------------------------------
module sar_key_search #(
    parameter int N = 4
) (
    input  logic             CLK,
    input  logic             RST,
    sar_key_search_if.slave  bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TEST   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [N-1:0]    trial_q, trial_d;
    logic [N-1:0]    result_q, result_d;
    logic            found_q, found_d;
    logic            err_q, err_d;

    logic [2:0]      flags;
    logic            flags_legal;

    assign flags       = {bus.GT, bus.EQ, bus.LT};
    assign flags_legal = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            trial_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        trial_d  = trial_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d        = S_TEST;
                    k_d            = KW'(N - 1);
                    trial_d        = '0;
                    trial_d[N-1]   = 1'b1;
                    result_d       = '0;
                    found_d        = 1'b0;
                    err_d          = 1'b0;
                end
            end

            S_TEST: begin
                if (!flags_legal) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = trial_q;
                    state_d  = S_DONE;
                end else if (bus.EQ) begin
                    // Exact hit before all bits are decided: no need to verify.
                    found_d  = 1'b1;
                    result_d = trial_q;
                    state_d  = S_DONE;
                end else begin
                    // Trial overshot the key: this bit must be zero.
                    if (bus.GT) begin
                        trial_d[k_q] = 1'b0;
                    end
                    if (k_q != '0) begin
                        trial_d[k_q - 1'b1] = 1'b1;
                        k_d                 = k_q - 1'b1;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end

            S_VERIFY: begin
                // A GT/LT here means the comparator disagrees with its own
                // earlier answers; that is reported as not-found, not as ERR.
                found_d  = flags_legal && bus.EQ;
                if (!flags_legal) begin
                    err_d = 1'b1;
                end
                result_d = trial_q;
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.TRIAL  = trial_q;
    assign bus.RESULT = result_q;
    assign bus.FOUND  = found_q;
    assign bus.ERR    = err_q;
    assign bus.CMP_E  = (state_q == S_TEST) || (state_q == S_VERIFY);
    assign bus.BUSY   = (state_q == S_TEST) || (state_q == S_VERIFY);
    assign bus.DONE   = (state_q == S_DONE);

endmodule

// File: tb/tb_sar_key_search.sv
module tb_sar_key_search;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    sar_key_search_if #(.N(N)) bus ();

    sar_key_search #(.N(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference results of one search, filled by model()
    logic [N-1:0] exp_trial [0:N+1];
    int           exp_ncmp;
    logic [N-1:0] exp_result;
    logic         exp_found;
    logic         exp_err;

    // Behavioural reference: a binary search on integers. base accumulates the
    // bits already known; each step tries base + 2^k. fault_cyc selects the
    // compare cycle (1-based) whose flags are replaced by fault_flags.
    task automatic model(input logic [N-1:0] key, input int fault_cyc,
                         input logic [2:0] fault_flags);
        int         base;
        int         t;
        logic [2:0] f;
        bit         stopped;
        base     = 0;
        stopped  = 0;
        exp_err  = 1'b0;
        exp_found = 1'b0;
        exp_result = '0;
        exp_ncmp = 0;
        for (int s = 1; s <= N; s++) begin
            if (!stopped) begin
                t = base + (1 << (N - s));
                exp_trial[s] = N'(t);
                exp_ncmp = s;
                f = (s == fault_cyc) ? fault_flags
                                     : {t > int'(key), t == int'(key), t < int'(key)};
                if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin
                    exp_err = 1'b1; exp_found = 1'b0; exp_result = N'(t); stopped = 1;
                end else if (f == 3'b010) begin
                    exp_found = 1'b1; exp_result = N'(t); stopped = 1;
                end else if (f == 3'b001) begin
                    base = t;
                end
            end
        end
        if (!stopped) begin
            exp_trial[N+1] = N'(base);
            exp_ncmp = N + 1;
            f = ((N + 1) == fault_cyc) ? fault_flags
                                       : {base > int'(key), base == int'(key), base < int'(key)};
            exp_result = N'(base);
            exp_found  = (f == 3'b010);
            exp_err    = !(f == 3'b100 || f == 3'b010 || f == 3'b001);
        end
    endtask

    task automatic drive_flags(input logic [2:0] f);
        bus.GT = f[2];
        bus.EQ = f[1];
        bus.LT = f[0];
    endtask

    // One complete search. hold_start keeps START high while busy; leave_start
    // raises START in the DONE cycle so the next call is accepted straight away.
    task automatic run_search(input logic [N-1:0] key, input int fault_cyc,
                              input logic [2:0] fault_flags, input bit hold_start,
                              input bit leave_start);
        logic [2:0] f;
        model(key, fault_cyc, fault_flags);
        @(negedge CLK);
        bus.START = 1'b1;
        drive_flags(3'($urandom));
        @(posedge CLK);
        #1;
        if (!hold_start) bus.START = 1'b0;
        for (int c = 1; c <= exp_ncmp; c++) begin
            @(negedge CLK);
            vectors++;
            if ({bus.BUSY, bus.CMP_E, bus.DONE} !== 3'b110) begin
                miscompares++;
                $display("FAIL busy_status key=%0d cyc=%0d got BUSY/CMP_E/DONE=%b want 110",
                         key, c, {bus.BUSY, bus.CMP_E, bus.DONE});
            end
            vectors++;
            if (bus.TRIAL !== exp_trial[c]) begin
                miscompares++;
                $display("FAIL trial key=%0d cyc=%0d got %b want %b",
                         key, c, bus.TRIAL, exp_trial[c]);
            end
            if (c == 1) begin
                vectors++;
                if ({bus.RESULT, bus.FOUND, bus.ERR} !== '0) begin
                    miscompares++;
                    $display("FAIL start_clear key=%0d got RESULT=%b FOUND=%b ERR=%b want 0",
                             key, bus.RESULT, bus.FOUND, bus.ERR);
                end
            end
            f = (c == fault_cyc) ? fault_flags
                                 : {bus.TRIAL > key, bus.TRIAL == key, bus.TRIAL < key};
            drive_flags(f);
        end
        @(negedge CLK);
        vectors++;
        if ({bus.DONE, bus.BUSY, bus.CMP_E} !== 3'b100) begin
            miscompares++;
            $display("FAIL done_pulse key=%0d cyc=%0d got DONE/BUSY/CMP_E=%b want 100",
                     key, exp_ncmp + 1, {bus.DONE, bus.BUSY, bus.CMP_E});
        end
        vectors++;
        if ({bus.RESULT, bus.FOUND, bus.ERR, bus.TRIAL} !==
            {exp_result, exp_found, exp_err, exp_trial[exp_ncmp]}) begin
            miscompares++;
            $display("FAIL outcome key=%0d got RESULT=%b FOUND=%b ERR=%b TRIAL=%b want %b %b %b %b",
                     key, bus.RESULT, bus.FOUND, bus.ERR, bus.TRIAL,
                     exp_result, exp_found, exp_err, exp_trial[exp_ncmp]);
        end
        drive_flags(3'($urandom));
        bus.START = leave_start;
        if (!leave_start) begin
            @(negedge CLK);
            vectors++;
            if ({bus.DONE, bus.BUSY, bus.RESULT, bus.FOUND, bus.ERR, bus.TRIAL} !==
                {2'b00, exp_result, exp_found, exp_err, exp_trial[exp_ncmp]}) begin
                miscompares++;
                $display("FAIL idle_hold key=%0d got DONE=%b BUSY=%b RESULT=%b FOUND=%b ERR=%b TRIAL=%b",
                         key, bus.DONE, bus.BUSY, bus.RESULT, bus.FOUND, bus.ERR, bus.TRIAL);
            end
        end
        $display("search key=%0d fault_cyc=%0d result=%b found=%b err=%b done_cycle=%0d",
                 key, fault_cyc, bus.RESULT, bus.FOUND, bus.ERR, exp_ncmp + 1);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.START = 1'b0;
        drive_flags(3'b000);
        repeat (2) @(negedge CLK);
        vectors++;
        if ({bus.TRIAL, bus.RESULT, bus.CMP_E, bus.BUSY, bus.DONE, bus.FOUND, bus.ERR} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got TRIAL=%b RESULT=%b CMP_E=%b BUSY=%b DONE=%b FOUND=%b ERR=%b want all 0",
                     bus.TRIAL, bus.RESULT, bus.CMP_E, bus.BUSY, bus.DONE, bus.FOUND, bus.ERR);
        end
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({bus.BUSY, bus.DONE, bus.CMP_E} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset got BUSY/DONE/CMP_E=%b want 000",
                     {bus.BUSY, bus.DONE, bus.CMP_E});
        end
    endtask

    task automatic test_directed();
        run_search(4'd5,  0, 3'b000, 0, 0);
        run_search(4'd0,  0, 3'b000, 0, 0);
        run_search(4'd8,  0, 3'b000, 0, 0);
        run_search(4'd15, 0, 3'b000, 0, 0);
    endtask

    task automatic test_illegal_flags();
        run_search(4'd5, 2, 3'b101, 0, 0);
        run_search(4'd5, 0, 3'b000, 0, 0);
        run_search(4'd11, 1, 3'b000, 0, 0);
        run_search(4'd3, 5, 3'b111, 0, 0);
    endtask

    task automatic test_verify_mismatch();
        run_search(4'd0, 5, 3'b100, 0, 0);
    endtask

    task automatic test_abort();
        logic [2:0] f;
        bit         stray;
        @(negedge CLK);
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            f = {bus.TRIAL > 4'd9, bus.TRIAL == 4'd9, bus.TRIAL < 4'd9};
            drive_flags(f);
        end
        vectors++;
        if (bus.BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy got BUSY=%b want 1", bus.BUSY);
        end
        #1 RST = 1'b1;
        #1;
        vectors++;
        if ({bus.TRIAL, bus.RESULT, bus.CMP_E, bus.BUSY, bus.DONE, bus.FOUND, bus.ERR} !== '0) begin
            miscompares++;
            $display("FAIL async_abort got TRIAL=%b RESULT=%b CMP_E=%b BUSY=%b DONE=%b want all 0",
                     bus.TRIAL, bus.RESULT, bus.CMP_E, bus.BUSY, bus.DONE);
        end
        #1 RST = 1'b0;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) stray = 1;
        end
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done got activity=%b want 0", stray);
        end
        $display("abort key=9 during TEST");
    endtask

    task automatic test_start_hold();
        run_search(4'd9, 0, 3'b000, 1, 0);
        run_search(4'd9, 0, 3'b000, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_search(4'd3,  0, 3'b000, 0, 1);
        run_search(4'd12, 0, 3'b000, 0, 1);
        run_search(4'd7,  0, 3'b000, 0, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] key;
        int           fc;
        logic [2:0]   ff;
        for (int i = 0; i < 40; i++) begin
            key = N'($urandom_range(0, 15));
            fc  = 0;
            ff  = 3'b000;
            if ($urandom_range(0, 3) == 0) begin
                fc = $urandom_range(1, N + 1);
                ff = 3'($urandom);
            end
            run_search(key, fc, ff, ($urandom_range(0, 3) == 0), 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal_flags();
        test_verify_mismatch();
        test_abort();
        test_start_hold();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
